// File: rtl/wallace_pkg.sv
// Shared constants, carry-save pair type and reduction-depth helpers for the Wallace multiplier.
// WALLACE_MUL_SIGNED_EN adds the Baugh-Wooley constant row to the partial-product count.
package wallace_pkg;
  localparam int MUL_LATENCY = 3;
  localparam int MAX_WIDTH   = 32;
`ifdef WALLACE_MUL_SIGNED_EN
  localparam int PP_EXTRA = 1;
`else
  localparam int PP_EXTRA = 0;
`endif

  // Rows are zero-extended to the widest legal product.
  typedef struct packed {
    logic [2*MAX_WIDTH-1:0] sum;
    logic [2*MAX_WIDTH-1:0] carry;
  } csa_pair_t;

  // One 3:2 level turns each full group of three rows into two.
  function automatic int rows_after(input int rows);
    return 2 * (rows / 3) + rows % 3;
  endfunction

  function automatic int rows_at(input int width, input int level);
    int r;
    r = width + PP_EXTRA;
    for (int i = 0; i < level; i++) r = rows_after(r);
    return r;
  endfunction

  function automatic int reduce_levels(input int width);
    int r;
    int n;
    r = width + PP_EXTRA;
    n = 0;
    while (r > 2) begin
      r = rows_after(r);
      n++;
    end
    return n;
  endfunction
endpackage

// File: rtl/wallace_csa_tree.sv
// Combinational partial-product array and Wallace 3:2 reduction down to a sum/carry pair.
// WALLACE_MUL_SIGNED_EN enables Baugh-Wooley inversion and correction constants.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);
endmodule

module wallace_csa_tree
  import wallace_pkg::*;
#(
  parameter int WIDTH = 12
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  output csa_pair_t        csa
);
  localparam int PW = 2 * WIDTH;
  localparam int R0 = WIDTH + PP_EXTRA;
  localparam int LV = reduce_levels(WIDTH);

  logic [PW-1:0] rows [LV+1][R0];

  for (genvar i = 0; i < WIDTH; i++) begin : g_pp
    logic [WIDTH-1:0] bits;
`ifdef WALLACE_MUL_SIGNED_EN
    for (genvar j = 0; j < WIDTH; j++) begin : g_bit
      // Only cross terms touching exactly one sign bit are inverted; the corner is not.
      if ((i == WIDTH-1) != (j == WIDTH-1)) begin : g_inv
        assign bits[j] = (a[j] & b[i]) ^ signed_mode;
      end else begin : g_pass
        assign bits[j] = a[j] & b[i];
      end
    end
`else
    assign bits = a & {WIDTH{b[i]}};
`endif
    assign rows[0][i] = PW'(bits) << i;
  end

`ifdef WALLACE_MUL_SIGNED_EN
  assign rows[0][WIDTH] = signed_mode ? ((PW'(1) << WIDTH) | (PW'(1) << (PW-1))) : '0;
`else
  logic unused_signed_mode;
  assign unused_signed_mode = signed_mode;
`endif

  for (genvar l = 0; l < LV; l++) begin : g_lvl
    localparam int NR = rows_at(WIDTH, l);
    localparam int NG = NR / 3;
    localparam int NX = NR % 3;
    localparam int NN = 2 * NG + NX;
    for (genvar g = 0; g < NG; g++) begin : g_grp
      logic [PW-1:0] s;
      logic [PW-1:0] c;
      assign c[0] = 1'b0;
      for (genvar bt = 0; bt < PW; bt++) begin : g_col
        if (bt == PW-1) begin : g_top
          // Carry out of the top column falls outside the modulo-2^PW product.
          assign s[bt] = rows[l][3*g][bt] ^ rows[l][3*g+1][bt] ^ rows[l][3*g+2][bt];
        end else begin : g_fa
          full_adder u_fa (
            .a  (rows[l][3*g][bt]),
            .b  (rows[l][3*g+1][bt]),
            .ci (rows[l][3*g+2][bt]),
            .s  (s[bt]),
            .co (c[bt+1])
          );
        end
      end
      assign rows[l+1][2*g]   = s;
      assign rows[l+1][2*g+1] = c;
    end
    for (genvar k = 0; k < NX; k++) begin : g_fwd
      assign rows[l+1][2*NG+k] = rows[l][3*NG+k];
    end
    for (genvar k = NN; k < R0; k++) begin : g_zero
      assign rows[l+1][k] = '0;
    end
  end

  assign csa.sum   = (2*MAX_WIDTH)'(rows[LV][0]);
  assign csa.carry = (2*MAX_WIDTH)'(rows[LV][1]);
endmodule

// File: rtl/wallace_mul_pipe.sv
// Three-stage pipelined Wallace multiplier with bubble-collapsing valid/ready and a tag sideband.
// WALLACE_MUL_SIGNED_EN honours in_signed per transaction; otherwise all products are unsigned.
module wallace_mul_pipe
  import wallace_pkg::*;
#(
  parameter int WIDTH = 12,
  parameter int TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_signed,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_prod,
  output logic [TAG_W-1:0]   out_tag
);
  logic v1, v2, v3;
  logic ready1, ready2, ready3;
  logic [WIDTH-1:0]   s1_a, s1_b;
  logic [TAG_W-1:0]   s1_tag, s2_tag;
  logic [2*WIDTH-1:0] s2_sum, s2_carry;
  logic               tree_signed;
  csa_pair_t          csa;

  assign ready3    = !v3 | out_ready;
  assign ready2    = !v2 | ready3;
  assign ready1    = !v1 | ready2;
  assign in_ready  = ready1;
  assign out_valid = v3;

`ifdef WALLACE_MUL_SIGNED_EN
  logic s1_signed;
  always_ff @(posedge clk) begin
    if (rst)                      s1_signed <= 1'b0;
    else if (in_valid && ready1)  s1_signed <= in_signed;
  end
  assign tree_signed = s1_signed;
`else
  logic unused_signed;
  assign unused_signed = in_signed;
  assign tree_signed   = 1'b0;
`endif

  wallace_csa_tree #(.WIDTH(WIDTH)) u_tree (
    .a           (s1_a),
    .b           (s1_b),
    .signed_mode (tree_signed),
    .csa         (csa)
  );

  // Tree rows are zero-extended; only the low 2*WIDTH bits are meaningful.
  logic unused_csa;
  assign unused_csa = ^csa;

  always_ff @(posedge clk) begin
    if (rst) begin
      v1       <= 1'b0;
      v2       <= 1'b0;
      v3       <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_tag   <= '0;
      s2_sum   <= '0;
      s2_carry <= '0;
      s2_tag   <= '0;
      out_prod <= '0;
      out_tag  <= '0;
    end else begin
      if (ready1) begin
        v1 <= in_valid;
        if (in_valid) begin
          s1_a   <= in_a;
          s1_b   <= in_b;
          s1_tag <= in_tag;
        end
      end
      if (ready2) begin
        v2 <= v1;
        if (v1) begin
          s2_sum   <= csa.sum[2*WIDTH-1:0];
          s2_carry <= csa.carry[2*WIDTH-1:0];
          s2_tag   <= s1_tag;
        end
      end
      if (ready3) begin
        v3 <= v2;
        if (v2) begin
          out_prod <= s2_sum + s2_carry;
          out_tag  <= s2_tag;
        end
      end
    end
  end
endmodule

// File: tb/tb_wallace_mul_pipe.sv
// Randomised scoreboard bench for wallace_mul_pipe (WIDTH=12, TAG_W=4), with directed corner cases.
// Follows WALLACE_MUL_SIGNED_EN so the reference model matches the build under test.
module tb_wallace_mul_pipe;
  localparam int W  = 12;
  localparam int TW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_a = '0;
  logic [W-1:0]  in_b = '0;
  logic          in_signed = 1'b0;
  logic [TW-1:0] in_tag = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [2*W-1:0] out_prod;
  logic [TW-1:0] out_tag;

  wallace_mul_pipe #(.WIDTH(W), .TAG_W(TW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_signed (in_signed),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_prod  (out_prod),
    .out_tag   (out_tag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2*W-1:0] prod;
    logic [TW-1:0]  tag;
    int             cyc;
  } exp_t;

  exp_t           sb[$];
  int             checks = 0;
  int             errors = 0;
  int             cnt = 0;
  int             n_acc = 0;
  int             n_out = 0;
  bit             lat_on = 1'b0;
  bit             hold = 1'b0;
  logic [2*W-1:0] hold_prod;
  logic [TW-1:0]  hold_tag;
  logic [2*W-1:0] last_prod;
  logic [TW-1:0]  last_tag;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic s);
    logic signed [2*W-1:0] sa, sbv;
`ifdef WALLACE_MUL_SIGNED_EN
    if (s) begin
      sa  = {{W{a[W-1]}}, a};
      sbv = {{W{b[W-1]}}, b};
      return sa * sbv;
    end
`endif
    sa  = {{W{1'b0}}, a};
    sbv = {{W{1'b0}}, b};
    return (s & 1'b0) ? '0 : sa * sbv;
  endfunction

  // One clock: drive at the falling edge, observe just after, scoreboard the coming edge's transfers.
  task automatic cyc(input logic r, input logic iv, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic sg, input logic [TW-1:0] tg, input logic ordy);
    exp_t e;
    @(negedge clk);
    rst = r; in_valid = iv; in_a = a; in_b = b; in_signed = sg; in_tag = tg; out_ready = ordy;
    #1;
    cnt++;
    if (r) begin
      hold = 1'b0;
    end else begin
      if (hold) begin
        chk("hold_valid", 64'(out_valid), 64'd1);
        chk("hold_prod", 64'(out_prod), 64'(hold_prod));
        chk("hold_tag", 64'(out_tag), 64'(hold_tag));
      end
      if (out_valid && out_ready) begin
        n_out++;
        last_prod = out_prod;
        last_tag  = out_tag;
        if (sb.size() == 0) begin
          chk("spurious_output", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          chk("prod", 64'(out_prod), 64'(e.prod));
          chk("tag", 64'(out_tag), 64'(e.tag));
          if (lat_on) chk("latency", 64'(cnt - e.cyc), 64'd3);
        end
      end
      if (in_valid && in_ready) begin
        n_acc++;
        sb.push_back('{model(a, b, sg), tg, cnt});
      end
      hold      = out_valid && !out_ready;
      hold_prod = out_prod;
      hold_tag  = out_tag;
    end
  endtask

  task automatic idle(input int n, input logic ordy);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, '0, '0, 1'b0, '0, ordy);
  endtask

  initial begin
    int base;
    // Reset
    cyc(1'b1, 1'b0, '0, '0, 1'b0, '0, 1'b1);
    cyc(1'b1, 1'b0, '0, '0, 1'b0, '0, 1'b1);
    cyc(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b1);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_prod", 64'(out_prod), 64'd0);
    chk("rst_out_tag", 64'(out_tag), 64'd0);

    // Directed unsigned corner
    lat_on = 1'b1;
    base = n_out;
    cyc(1'b0, 1'b1, 12'hFFF, 12'hFFF, 1'b0, 4'd5, 1'b1);
    idle(4, 1'b1);
    chk("fff_count", 64'(n_out - base), 64'd1);
    chk("fff_prod", 64'(last_prod), 64'hFFE001);
    chk("fff_tag", 64'(last_tag), 64'd5);

    // Directed signed corner
    base = n_out;
    cyc(1'b0, 1'b1, 12'h800, 12'hFFF, 1'b1, 4'd9, 1'b1);
    idle(4, 1'b1);
    chk("sgn_count", 64'(n_out - base), 64'd1);
`ifdef WALLACE_MUL_SIGNED_EN
    chk("sgn_prod", 64'(last_prod), 64'h000800);
`else
    chk("sgn_prod", 64'(last_prod), 64'h7FF800);
`endif

    // Streaming at full rate
    base = n_out;
    for (int i = 0; i < 100; i++)
      cyc(1'b0, 1'b1, W'($urandom), W'($urandom), 1'($urandom), TW'(i % 16), 1'b1);
    idle(4, 1'b1);
    chk("stream_count", 64'(n_out - base), 64'd100);
    chk("stream_empty", 64'(sb.size()), 64'd0);

    // Backpressure fill and release
    lat_on = 1'b0;
    base = n_acc;
    for (int i = 0; i < 6; i++)
      cyc(1'b0, 1'b1, W'($urandom), W'($urandom), 1'($urandom), TW'(i), 1'b0);
    chk("bp_accepted", 64'(n_acc - base), 64'd3);
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    chk("bp_out_valid", 64'(out_valid), 64'd1);
    base = n_out;
    cyc(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b1);
    chk("bp_release_ready", 64'(in_ready), 64'd1);
    idle(5, 1'b1);
    chk("bp_drained", 64'(n_out - base), 64'd3);
    chk("bp_empty", 64'(sb.size()), 64'd0);

    // Random valid/ready stalls
    for (int i = 0; i < 300; i++)
      cyc(1'b0, 1'($urandom), W'($urandom), W'($urandom), 1'($urandom), TW'($urandom),
          1'($urandom));
    idle(6, 1'b1);
    chk("rand_empty", 64'(sb.size()), 64'd0);
    chk("rand_balance", 64'(n_out), 64'(n_acc));

    // Reset with a full pipeline
    for (int i = 0; i < 4; i++)
      cyc(1'b0, 1'b1, W'($urandom), W'($urandom), 1'($urandom), TW'(i), 1'b0);
    chk("pre_rst_full", 64'(out_valid), 64'd1);
    cyc(1'b1, 1'b0, '0, '0, 1'b0, '0, 1'b1);
    sb.delete();
    cyc(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b1);
    chk("post_rst_valid", 64'(out_valid), 64'd0);
    lat_on = 1'b1;
    base = n_out;
    cyc(1'b0, 1'b1, 12'h123, 12'h456, 1'b0, 4'd3, 1'b1);
    idle(5, 1'b1);
    chk("post_rst_count", 64'(n_out - base), 64'd1);
    chk("post_rst_prod", 64'(last_prod), 64'h04EDC2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
